// File: rtl/fn_share_arbiter.sv
// Round-robin arbiter that serialises calls from N requesters onto one shared
// start/done function instance, routing results back and aborting stalled calls.
`ifndef intN
`define intN 16
`endif

module fn_share_arbiter #(
   parameter int N       = 4,
   parameter int W       = `intN,
   parameter int TIMEOUT = 1024
) (
   input  logic           clk,
   input  logic           nrst,
   input  logic [N-1:0]   req_valid,
   input  logic [N*W-1:0] req_arg,
   output logic [N-1:0]   req_ready,
   output logic [N-1:0]   resp_valid,
   output logic           resp_err,
   output logic [W-1:0]   resp_data,
   output logic           fn_read,
   output logic [W-1:0]   fn_arg,
   input  logic           fn_write,
   input  logic [W-1:0]   fn_result,
   output logic           busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [PW-1:0] IDX_LAST = PW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] g_q, g_d;
   logic [W-1:0]  arg_q, arg_d;
   logic [W-1:0]  data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   logic          found;
   logic [PW-1:0] pick;
   logic [W-1:0]  pick_arg;

   // Two passes: first the requesters at or above ptr, then wrap to the bottom.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && req_valid[i] && (PW'(i) >= ptr_q)) begin
            found = 1'b1;
            pick  = PW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req_valid[i]) begin
            found = 1'b1;
            pick  = PW'(i);
         end
      end
   end

   always_comb begin
      pick_arg = '0;
      for (int i = 0; i < N; i++) begin
         if (pick == PW'(i)) begin
            pick_arg = req_arg[i*W +: W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      g_d     = g_q;
      arg_d   = arg_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               g_d     = pick;
               arg_d   = pick_arg;
               ptr_d   = (pick == IDX_LAST) ? '0 : pick + 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (fn_write) begin
               data_d  = fn_result;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         g_q     <= '0;
         arg_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         arg_q   <= arg_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // The accept pulse is combinational on req_valid, so it is also gated by
   // nrst to keep it quiet while reset is held with requests pending.
   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      for (int i = 0; i < N; i++) begin
         req_ready[i]  = nrst && (state_q == S_IDLE) && found && (pick == PW'(i));
         resp_valid[i] = (state_q == S_RESP) && (g_q == PW'(i));
      end
   end

   assign resp_err  = (state_q == S_RESP) && err_q;
   assign resp_data = data_q;
   assign fn_read   = (state_q == S_ISSUE);
   assign fn_arg    = arg_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/fn_share_arbiter.md
# fn_share_arbiter

Round-robin arbiter that shares one instance of a compiled function module among N requesters. The shared module uses the standard start/done pair: `read` pulses to start with argument `a`, and `write` pulses when result `b` is valid. The arbiter sits between the requesting logic and the shared instance (for example, one `tests_fibl` serving several callers). It serialises calls, routes each result back to its caller, and enforces a completion timeout.

## Interface
Parameters:
- `N`, 4, number of requesters (2..8).
- `W`, `` `intN ``, argument/result width.
- `TIMEOUT`, 1024, maximum cycles spent in WAIT before a call is aborted (at least 2).

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N  request pending, one bit per requester; held until accepted.
- `req_arg`  in  N*W  arguments; requester i uses bits [i*W +: W].
- `req_ready`  out  N  one-hot, one-cycle accept pulse.
- `resp_valid`  out  N  one-hot, one-cycle completion pulse.
- `resp_err`  out  1  qualifies `resp_valid`: 1 means the call timed out.
- `resp_data`  out  W  result; holds its value until the next response.
- `fn_read`  out  1  start pulse to the shared module.
- `fn_arg`  out  W  argument to the shared module.
- `fn_write`  in  1  done pulse from the shared module.
- `fn_result`  in  W  result from the shared module; valid when `fn_write`=1.
- `busy`  out  1  high in every state except IDLE.

## Operation
States: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - If any `req_valid` is set, grant the first set bit found searching from `ptr` upward, modulo N.
  - Pulse that requester's `req_ready`, capture `g`, and latch its argument into `fn_arg`.
  - Set `ptr` = (g+1) mod N, then go to ISSUE.
  - If no request is set, stay in IDLE.
- **ISSUE**
  - Assert `fn_read` for exactly one cycle, clear the timeout counter, go to WAIT.
- **WAIT**
  - On `fn_write`: latch `fn_result` into `resp_data`, clear the error flag, go to RESP.
  - Otherwise increment the counter. When counter = TIMEOUT-1 and `fn_write` is still 0: set the error flag, leave `resp_data` unchanged, go to RESP.
- **RESP**
  - Pulse `resp_valid[g]` with `resp_err` = error flag, then go to IDLE.

Rules:
- `fn_arg` stays stable from ISSUE through the end of WAIT. It changes only on a new grant.
- `fn_write` is ignored in every state except WAIT. A late `fn_write` after a timeout is dropped.
- A requester may lower `req_valid` before it is granted. `req_valid` is sampled only in IDLE.
- `req_ready` is at most one-hot. The same holds for `resp_valid`.
- `resp_err` is meaningful only when `resp_valid` is high; it is 0 otherwise.
- Reset values:
  - State is IDLE and `ptr` = 0.
  - `req_ready`, `resp_valid`, `resp_err`, `fn_read` and `busy` are 0.
  - `resp_data`, `fn_arg` and the counter are 0.
- Reset mid-call: all outputs return to their reset values asynchronously. The pending call is abandoned with no response. A `fn_write` that arrives after reset is ignored.

## Timing
- Accept to `fn_read`: 1 cycle. `req_ready` is high in cycle t and `fn_read` is high in cycle t+1.
- When `fn_write` is high in WAIT at cycle u, `resp_valid` is high in cycle u+1.
- Minimum turnaround is 4 cycles from accept to the next accept (IDLE, ISSUE, WAIT, RESP), and assumes `fn_write` arrives in the first WAIT cycle.
- A timeout response occurs TIMEOUT+1 cycles after `fn_read`.
- Fairness: a continuously asserted request is granted within N grants.

## Test plan
- **Single call.** Use the fib model with `` `intN ``=16. Set `req_valid[0]`=1 and arg 21. Require `req_ready[0]` for one cycle, then `fn_arg`=21 with one `fn_read` pulse. Require `resp_valid[0]` with `resp_data`=10946 and `resp_err`=0, and `busy` low afterwards.
- **Round-robin.** Hold all four requests with args 1, 2, 3, 4 (fib model). Require grant order 0, 1, 2, 3 and then 0 again. Require results 1, 1, 2, 3 to go to the matching `resp_valid` bits.
- **Pointer wrap.** Set `ptr`=3 (after a grant to 2), then assert requests 1 and 3. Require 3 granted before 1.
- **Timeout.** Use TIMEOUT=8 with the callee never asserting `fn_write`. Require `resp_valid[g]` with `resp_err`=1 exactly 9 cycles after `fn_read`, and `resp_data` unchanged. Then inject a late `fn_write`: require no response.
- **Zero-latency callee.** Assert `fn_write` in the first WAIT cycle. Require a 4-cycle accept-to-accept turnaround when the next request is already pending.
- **Reset mid-WAIT.** Pulse `nrst` low during WAIT. Require all outputs at their reset values immediately, no `resp_valid` afterwards, and the next request granted from `ptr`=0.
